// File: rtl/cnn_pkg.sv
// Shared definitions for the activation streaming path: FSM state type,
// default geometry and the index-width helper.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_OUTPUT_NODES = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // A single-node vector still needs a 1-bit index port.
    function automatic int idx_width(input int nodes);
        return (nodes <= 1) ? 1 : $clog2(nodes);
    endfunction

endpackage

// File: rtl/relu_unit.sv
// Single-node combinational ReLU: negative two's-complement values clamp to zero.
module relu_unit
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_node,
    output logic [DATA_WIDTH-1:0] o_node
);

    assign o_node = i_node[DATA_WIDTH-1] ? '0 : i_node;

endmodule

// File: rtl/act_stream_serializer.sv
// Captures a packed activation vector (ReLU applied on capture) and streams it
// out one node per valid/ready handshake. Define ACT_ARGMAX_EN for argmax reporting.
module act_stream_serializer
    import cnn_pkg::*;
#(
    parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int OUTPUT_NODES = DEF_OUTPUT_NODES,
    localparam int IDX_W        = idx_width(OUTPUT_NODES)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] input_fc,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [IDX_W-1:0]                   out_index,
    output logic                               out_last,
    output logic                               busy,
`ifdef ACT_ARGMAX_EN
    output logic [IDX_W-1:0]                   max_index,
    output logic                               max_valid,
`endif
    output logic [1:0]                         o_dbg_state
);

    // Handshake rule on both sides: a transfer happens on a rising edge where
    // valid and ready are both high; valid-side outputs hold until that edge.

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_STREAM = ST_STREAM;
`ifdef ACT_ARGMAX_EN
    localparam logic [1:0] S_REPORT = ST_REPORT;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NODES - 1);

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_buf [OUTPUT_NODES];

    logic [DATA_WIDTH-1:0] w_relu [OUTPUT_NODES];
    logic [DATA_WIDTH-1:0] w_sel;
    logic                  w_capture;
    logic                  w_in_stream;
    logic                  w_accept;
    logic                  w_at_last;

    genvar g;
    for (g = 0; g < OUTPUT_NODES; g++) begin : g_relu
        relu_unit #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
            .i_node (input_fc[DATA_WIDTH*g +: DATA_WIDTH]),
            .o_node (w_relu[g])
        );
    end

    assign w_capture   = (r_state == S_IDLE) && in_valid;
    assign w_in_stream = (r_state == S_STREAM);
    assign w_accept    = w_in_stream && out_ready;
    assign w_at_last   = (r_idx == LAST_IDX);

    // Compare-based mux keeps the select legal for non-power-of-two node counts.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < OUTPUT_NODES; i++) begin
            if (r_idx == IDX_W'(i)) w_sel = r_buf[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_STREAM;
                        r_idx   <= '0;
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (w_at_last) begin
`ifdef ACT_ARGMAX_EN
                            r_state <= S_REPORT;
`else
                            r_state <= S_IDLE;
`endif
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUTPUT_NODES; i++) r_buf[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < OUTPUT_NODES; i++) r_buf[i] <= w_relu[i];
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = w_in_stream;
    assign out_data    = w_in_stream ? w_sel : '0;
    assign out_index   = w_in_stream ? r_idx : '0;
    assign out_last    = w_in_stream && w_at_last;
    assign o_dbg_state = r_state;

`ifdef ACT_ARGMAX_EN
    logic [DATA_WIDTH-1:0] r_max_val;
    logic [IDX_W-1:0]      r_max_idx;

    // Values are post-ReLU (non-negative), so an unsigned strict compare
    // keeps the lowest index on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_capture) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_accept && (w_sel > r_max_val)) begin
            r_max_val <= w_sel;
            r_max_idx <= r_idx;
        end
    end

    assign max_index = r_max_idx;
    assign max_valid = (r_state == S_REPORT);
`endif

endmodule

// File: tb/tb_act_stream_serializer.sv
// Bench for act_stream_serializer: directed steps with random vectors, scored
// against a node-list model; a second single-node instance covers the N=1 case.
module tb_act_stream_serializer;

    localparam int DW = 32;
    localparam int N  = 32;
    localparam int IW = 5;
    localparam int EW = 1 + IW + DW;
`ifdef ACT_ARGMAX_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] input_fc;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic            busy;
    logic [1:0]      dbg_state;
`ifdef ACT_ARGMAX_EN
    logic [IW-1:0]   max_index;
    logic            max_valid;
    logic [0:0]      n1_max_index;
    logic            n1_max_valid;
`endif

    logic            n1_in_valid;
    logic            n1_in_ready;
    logic [DW-1:0]   n1_input_fc;
    logic            n1_out_valid;
    logic            n1_out_ready;
    logic [DW-1:0]   n1_out_data;
    logic [0:0]      n1_out_index;
    logic            n1_out_last;
    logic            n1_busy;
    logic [1:0]      n1_dbg_state;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_out   = '0;

    act_stream_serializer #(.DATA_WIDTH(DW), .OUTPUT_NODES(N)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .input_fc    (input_fc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
`ifdef ACT_ARGMAX_EN
        .max_index   (max_index),
        .max_valid   (max_valid),
`endif
        .o_dbg_state (dbg_state)
    );

    act_stream_serializer #(.DATA_WIDTH(DW), .OUTPUT_NODES(1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (n1_in_valid),
        .in_ready    (n1_in_ready),
        .input_fc    (n1_input_fc),
        .out_valid   (n1_out_valid),
        .out_ready   (n1_out_ready),
        .out_data    (n1_out_data),
        .out_index   (n1_out_index),
        .out_last    (n1_out_last),
        .busy        (n1_busy),
`ifdef ACT_ARGMAX_EN
        .max_index   (n1_max_index),
        .max_valid   (n1_max_valid),
`endif
        .o_dbg_state (n1_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: the element list a vector must produce
    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
        return ($signed(v) < 0) ? '0 : v;
    endfunction

    task automatic push_vector(input logic [N*DW-1:0] v);
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] node;
            node = v[i*DW +: DW];
            exp_q.push_back({(i == N - 1) ? 1'b1 : 1'b0, IW'(i), relu(node)});
        end
    endtask

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    // driver: called at posedge+1 with the DUT idle; returns just after capture
    task automatic send_vec(input logic [N*DW-1:0] v);
        push_vector(v);
        in_valid = 1'b1;
        input_fc = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        input_fc = rand_vec();
    endtask

    // mode 0: out_ready held, 1: toggles starting high, 2: random
    task automatic run_stream(input int mode, output int cnt);
        int ph;
        cnt = 0;
        ph  = 0;
        while (busy && cnt < 400) begin
            cnt++;
            if (mode == 1) out_ready = (ph % 2 == 0);
            else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
            ph++;
            @(posedge clk); #1;
        end
        check("idle_timeout", busy, 0);
        out_ready = 1'b1;
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [EW-1:0] cur;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            cur = {out_last, out_index, out_data};
            if (prev_stall && out_valid) check("stall_hold", cur, prev_out);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_elem", cur, '1);
                else check("elem", cur, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = cur;
        end
    end

    initial begin
        logic [N*DW-1:0] v;
        logic [N*DW-1:0] va;
        logic [N*DW-1:0] vb;
        int cnt;
        int k;

        reset        = 1'b1;
        in_valid     = 1'b0;
        input_fc     = '0;
        out_ready    = 1'b0;
        n1_in_valid  = 1'b0;
        n1_input_fc  = '0;
        n1_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last",  out_last,  0);
        check("rst_busy",      busy,      0);
        check("rst_state",     dbg_state, cnn_pkg::ST_IDLE);
        check("rst_n1_state",  n1_dbg_state, cnn_pkg::ST_IDLE);
`ifdef ACT_ARGMAX_EN
        check("rst_max_index", max_index, 0);
        check("rst_max_valid", max_valid, 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready",    in_ready,    1);
        check("rel_n1_in_ready", n1_in_ready, 1);

        // directed vector, ready held high
        v = '0;
        v[31:0]  = 32'h0000_0005;
        v[63:32] = 32'hFFFF_FFFE;
        out_ready = 1'b1;
        send_vec(v);
        check("first_valid", out_valid, 1);
        check("first_index", out_index, 0);
        check("first_data",  out_data,  5);
        check("in_ready_low", in_ready, 0);
        run_stream(0, cnt);
        check("busy_cycles", cnt, N + EXTRA);
        check("q_drained_a", exp_q.size(), 0);

        // ready toggling every cycle
        send_vec(rand_vec());
        run_stream(1, cnt);
        check("toggle_cycles", cnt, 2 * N - 1 + EXTRA);
        check("q_drained_b", exp_q.size(), 0);

        // in_valid held high across two vectors
        va = rand_vec();
        vb = rand_vec();
        push_vector(va);
        push_vector(vb);
        in_valid = 1'b1;
        input_fc = va;
        k = 0;
        while (!busy && k < 10) begin k++; @(posedge clk); #1; end
        input_fc = vb;
        k = 0;
        while (busy && k < 200) begin k++; @(posedge clk); #1; end
        cnt = 0;
        while (!busy && cnt < 10) begin cnt++; @(posedge clk); #1; end
        in_valid = 1'b0;
        check("idle_gap", cnt, 1);
        run_stream(0, cnt);
        check("q_drained_c", exp_q.size(), 0);

        // random backpressure over several vectors
        for (int r = 0; r < 4; r++) begin
            send_vec(rand_vec());
            run_stream(2, cnt);
        end
        check("q_drained_d", exp_q.size(), 0);

        // reset in the middle of a stream
        send_vec(rand_vec());
        k = 0;
        while (out_index != IW'(10) && k < 100) begin k++; @(posedge clk); #1; end
        check("idx10_reached", out_index, 10);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data",  out_data,  0);
        check("mid_rst_index", out_index, 0);
        check("mid_rst_last",  out_last,  0);
        check("mid_rst_busy",  busy,      0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rel_in_ready", in_ready, 1);
        send_vec(rand_vec());
        check("restart_index", out_index, 0);
        run_stream(2, cnt);
        check("q_drained_e", exp_q.size(), 0);

`ifdef ACT_ARGMAX_EN
        v = '0;
        v[3*DW +: DW] = 32'h0000_0040;
        v[7*DW +: DW] = 32'h0000_0040;
        v[5*DW +: DW] = 32'h8000_0000;
        v[9*DW +: DW] = 32'h0000_0011;
        send_vec(v);
        k = 0;
        while (!(out_valid && out_last) && k < 100) begin k++; @(posedge clk); #1; end
        @(posedge clk); #1;
        check("argmax_valid",  max_valid, 1);
        check("argmax_index",  max_index, 3);
        @(posedge clk); #1;
        check("argmax_valid_drop", max_valid, 0);
        check("argmax_hold",   max_index, 3);
        check("q_drained_f", exp_q.size(), 0);
`endif

        // single-node instance
        n1_in_valid = 1'b1;
        n1_input_fc = 32'h8000_0001;
        @(posedge clk); #1;
        n1_in_valid = 1'b0;
        n1_input_fc = $urandom;
        check("n1_valid", n1_out_valid, 1);
        check("n1_data",  n1_out_data,  0);
        check("n1_index", n1_out_index, 0);
        check("n1_last",  n1_out_last,  1);
        @(posedge clk); #1;
        check("n1_done_valid", n1_out_valid, 0);
        repeat (EXTRA) @(posedge clk);
        #1;
        check("n1_idle", n1_busy, 0);
        n1_in_valid = 1'b1;
        n1_input_fc = 32'h0000_1234;
        @(posedge clk); #1;
        n1_in_valid = 1'b0;
        check("n1_pos_data", n1_out_data, 32'h1234);
        check("n1_pos_last", n1_out_last, 1);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/act_stream_serializer.md
ACT_STREAM_SERIALIZER -- requirements
Module: act_stream_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, bit width of one node value (two's complement).
REQ-002 The block SHALL have parameter OUTPUT_NODES, default 32, number of nodes per input vector.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  input_fc holds a valid vector.
REQ-006 in_ready  output  1  block can accept a vector.
REQ-007 input_fc  input  DATA_WIDTH*OUTPUT_NODES  packed node vector; node i at bits [DATA_WIDTH*i +: DATA_WIDTH].
REQ-008 out_valid  output  1  out_data/out_index/out_last are valid.
REQ-009 out_ready  input  1  downstream accepts the current element.
REQ-010 out_data  output  DATA_WIDTH  ReLU-applied node value.
REQ-011 out_index  output  IDX_W  node index of out_data; IDX_W = max(1, clog2(OUTPUT_NODES)).
REQ-012 out_last  output  1  high with the element whose out_index = OUTPUT_NODES-1.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, STREAM, and REPORT (REPORT exists only with ACT_ARGMAX_EN).
REQ-015 IDLE: in_ready = 1, out_valid = 0; in_valid & in_ready at a rising edge captures input_fc into an internal buffer, index counter = 0, next state STREAM.
REQ-016 Capture applies ReLU per node: sign bit (MSB) = 1 -> stored as 0; otherwise stored unchanged.
REQ-017 in_ready = 0 in STREAM and REPORT; in_valid and input_fc are ignored there; input_fc need not be held after capture.
REQ-018 STREAM: out_valid = 1, out_data = buffer[index], out_index = index, out_last = (index == OUTPUT_NODES-1).
REQ-019 out_valid & out_ready at a rising edge: if out_last = 0, index increments by 1; if out_last = 1, next state IDLE (REPORT with ACT_ARGMAX_EN).
REQ-020 out_valid = 1 with out_ready = 0: out_data, out_index, out_last SHALL hold stable until accepted.
REQ-021 Latency: first element valid the cycle after capture; with out_ready held high, one element per cycle, OUTPUT_NODES cycles per vector.
REQ-022 Back-to-back vectors: next capture no earlier than the cycle after returning to IDLE (one idle cycle between vectors).
REQ-023 OUTPUT_NODES = 1: one element with out_last = 1, index stays 0.

Reset
REQ-024 reset = 1 asynchronously forces state IDLE, index 0, buffer 0, out_valid 0, out_data 0, out_index 0, out_last 0, busy 0, in_ready 1 (after release); with ACT_ARGMAX_EN max_index 0, max_valid 0.
REQ-025 Reset mid-stream SHALL abandon the vector; no further elements of it are emitted.

Configuration
REQ-026 Macro ACT_ARGMAX_EN defined: extra outputs max_index (IDX_W) and max_valid (1); running max/argmax updated on each accepted element using strict greater-than, so ties keep the lowest index; after the last handshake the FSM enters REPORT for exactly one cycle with max_valid = 1, then IDLE; max_index holds until the next capture.
REQ-027 ACT_ARGMAX_EN undefined: no max_index/max_valid ports, no REPORT state, no comparator logic; last handshake returns directly to IDLE.

Structure
REQ-028 Shared package cnn_pkg holds the FSM state enum, DATA_WIDTH/OUTPUT_NODES defaults and the IDX_W computation function.
REQ-029 One sub-module relu_unit (single-node combinational ReLU, DATA_WIDTH parameter) instantiated OUTPUT_NODES times on the capture path.

Verification
REQ-030 Vector with node0 = 0x00000005, node1 = 0xFFFFFFFE, others 0, out_ready = 1 -> out_data 5, 0, 0, ...; out_last only at index 31; busy high for 32 cycles.
REQ-031 out_ready toggled 1/0 each cycle during stream -> every element appears exactly once, outputs stable while stalled, 63 cycles total.
REQ-032 in_valid held high continuously with two different vectors -> second captured only after first out_last handshake plus one IDLE cycle; no element lost or duplicated.
REQ-033 reset asserted when out_index = 10 -> outputs zero immediately, in_ready = 1 after release, new vector streams from index 0.
REQ-034 ACT_ARGMAX_EN, nodes 3 and 7 = 0x00000040 (max, tie), node 5 = 0x80000000 -> max_index = 3, max_valid high one cycle after last handshake.
REQ-035 OUTPUT_NODES = 1, input 0x80000001 -> single element out_data 0, out_index 0, out_last 1.
